// File: rtl/shiftreg_sequencer_if.sv
// Word-load request/acknowledge bundle between the
// configuration logic and the shift-register sequencer.
interface shiftreg_sequencer_if #(
  parameter int SIZESRDYN  = 16,
  parameter int SIZESRSTAT = 88
);

  logic                  DYN_REQ;
  logic [SIZESRDYN-1:0]  DYN_DATA;
  logic                  DYN_ACK;

  logic                  STAT_REQ;
  logic [SIZESRSTAT-1:0] STAT_DATA;
  logic                  STAT_ACK;

  modport master (
    output DYN_REQ,
    output DYN_DATA,
    input  DYN_ACK,
    output STAT_REQ,
    output STAT_DATA,
    input  STAT_ACK
  );

  modport slave (
    input  DYN_REQ,
    input  DYN_DATA,
    output DYN_ACK,
    input  STAT_REQ,
    input  STAT_DATA,
    output STAT_ACK
  );

endinterface

// File: rtl/shiftreg_sequencer.sv
// Round-robin serial loader that shifts dynamic/static
// words into the generator and commits them to its latches.
module shiftreg_sequencer #(
  parameter int SIZESRDYN  = 16,
  parameter int SIZESRSTAT = 88,
  parameter int SIZECNT    = 7
) (
  input  logic                 CLK,
  input  logic                 RST,
  shiftreg_sequencer_if.slave  req,
  output logic                 SELDYN,
  output logic                 SELSTAT,
  output logic                 SDATA,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int PAD = SIZESRSTAT - SIZESRDYN;
  localparam int MSB = SIZESRSTAT - 1;

  localparam logic [SIZECNT-1:0] DYN_LAST =
    SIZECNT'(SIZESRDYN - 1);
  localparam logic [SIZECNT-1:0] STAT_LAST =
    SIZECNT'(SIZESRSTAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_DYN,
    SHIFT_STAT,
    COMMIT_DYN,
    COMMIT_STAT,
    GAP
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [MSB:0]         sr_q;
  logic [MSB:0]         sr_d;
  logic [SIZECNT-1:0]   cnt_q;
  logic [SIZECNT-1:0]   cnt_d;
  logic                 last_dyn_q;
  logic                 last_dyn_d;

  logic                 dyn_ack_q;
  logic                 dyn_ack_d;
  logic                 stat_ack_q;
  logic                 stat_ack_d;
  logic                 seldyn_d;
  logic                 selstat_d;
  logic                 sdata_d;
  logic                 busy_d;
  logic                 done_d;

  logic                 grant_dyn;
  logic                 grant_stat;
  logic [MSB:0]         dyn_word;

  // Dynamic words ride left-aligned so both sides shift from the same MSB.
  assign dyn_word = {req.DYN_DATA, {PAD{1'b0}}};

  assign grant_dyn =
    req.DYN_REQ &&
    (!req.STAT_REQ || !last_dyn_q);

  assign grant_stat =
    req.STAT_REQ &&
    (!req.DYN_REQ || last_dyn_q);

  assign req.DYN_ACK  = dyn_ack_q;
  assign req.STAT_ACK = stat_ack_q;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    last_dyn_d = last_dyn_q;
    dyn_ack_d  = 1'b0;
    stat_ack_d = 1'b0;
    seldyn_d   = 1'b0;
    selstat_d  = 1'b0;
    sdata_d    = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE, GAP: begin
        state_d = IDLE;
        if (grant_dyn) begin
          state_d    = SHIFT_DYN;
          sr_d       = dyn_word << 1;
          sdata_d    = dyn_word[MSB];
          cnt_d      = DYN_LAST;
          last_dyn_d = 1'b1;
          dyn_ack_d  = 1'b1;
          seldyn_d   = 1'b1;
        end else if (grant_stat) begin
          state_d    = SHIFT_STAT;
          sr_d       = req.STAT_DATA << 1;
          sdata_d    = req.STAT_DATA[MSB];
          cnt_d      = STAT_LAST;
          last_dyn_d = 1'b0;
          stat_ack_d = 1'b1;
          selstat_d  = 1'b1;
        end
      end

      SHIFT_DYN: begin
        if (cnt_q == '0) begin
          state_d   = COMMIT_DYN;
          selstat_d = 1'b1;
        end else begin
          seldyn_d = 1'b1;
          sdata_d  = sr_q[MSB];
          sr_d     = sr_q << 1;
          cnt_d    = cnt_q - 1'b1;
        end
      end

      SHIFT_STAT: begin
        if (cnt_q == '0) begin
          state_d  = COMMIT_STAT;
          seldyn_d = 1'b1;
        end else begin
          selstat_d = 1'b1;
          sdata_d   = sr_q[MSB];
          sr_d      = sr_q << 1;
          cnt_d     = cnt_q - 1'b1;
        end
      end

      COMMIT_DYN, COMMIT_STAT: begin
        state_d = GAP;
        done_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      last_dyn_q <= 1'b0;
      dyn_ack_q  <= 1'b0;
      stat_ack_q <= 1'b0;
      SELDYN     <= 1'b0;
      SELSTAT    <= 1'b0;
      SDATA      <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      last_dyn_q <= last_dyn_d;
      dyn_ack_q  <= dyn_ack_d;
      stat_ack_q <= stat_ack_d;
      SELDYN     <= seldyn_d;
      SELSTAT    <= selstat_d;
      SDATA      <= sdata_d;
      BUSY       <= busy_d;
      DONE       <= done_d;
    end
  end

endmodule

// File: tb/tb_shiftreg_sequencer.sv
// Randomised bench for shiftreg_sequencer against a
// job-level reference model and a behavioural generator.
module tb_shiftreg_sequencer;

  localparam int DW = 16;
  localparam int SW = 88;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic seldyn, selstat, sdata, busy, done;

  shiftreg_sequencer_if #(
    .SIZESRDYN(DW), .SIZESRSTAT(SW)
  ) rif ();

  shiftreg_sequencer #(
    .SIZESRDYN(DW), .SIZESRSTAT(SW), .SIZECNT(7)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .req(rif),
    .SELDYN(seldyn),
    .SELSTAT(selstat),
    .SDATA(sdata),
    .BUSY(busy),
    .DONE(done)
  );

  always #5 clk = ~clk;

  // behavioural generator: shift registers plus commit latches
  logic [DW-1:0] dsr = '0;
  logic [DW-1:0] dlatch = '0;
  logic [SW-1:0] ssr = '0;
  logic [SW-1:0] slatch = '0;
  logic pd = 1'b0;
  logic ps = 1'b0;

  always @(posedge clk) begin
    if (seldyn === 1'b1) dsr <= {dsr[DW-2:0], sdata};
    if (selstat === 1'b1) ssr <= {ssr[SW-2:0], sdata};
    if (selstat === 1'b1 && pd) dlatch <= dsr;
    if (seldyn === 1'b1 && ps) slatch <= ssr;
    pd <= (seldyn === 1'b1);
    ps <= (selstat === 1'b1);
  end

  a_sel: assert property (@(posedge clk) !(seldyn && selstat))
    else $error("FAIL sel_overlap both selects high");
  a_dack: assert property (@(posedge clk)
    rif.DYN_ACK |-> $past(rif.DYN_REQ))
    else $error("FAIL dyn_ack_no_req");
  a_sack: assert property (@(posedge clk)
    rif.STAT_ACK |-> $past(rif.STAT_REQ))
    else $error("FAIL stat_ack_no_req");

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(
    input string tag,
    input logic [SW-1:0] obs,
    input logic [SW-1:0] exp
  );
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s obs=%h exp=%h t=%0t",
                  tag, obs, exp, $time);
  endtask

  // job-level model: one active job, its position in the
  // shift/commit/gap sequence, and the round-robin memory
  bit             m_act = 0;
  bit             m_dyn = 0;
  bit             m_ack = 0;
  bit             m_last_dyn = 0;
  logic [SW-1:0]  m_word = '0;
  int             m_len = 0;
  int             m_pos = 0;

  task automatic model_edge();
    bit g;
    m_ack = 0;
    if (rst) begin
      m_act = 0;
      m_last_dyn = 0;
      return;
    end
    if ((!m_act || m_pos == m_len + 1) &&
        (rif.DYN_REQ || rif.STAT_REQ)) begin
      g = (rif.DYN_REQ && rif.STAT_REQ) ? !m_last_dyn
                                         : rif.DYN_REQ;
      m_last_dyn = g;
      m_dyn = g;
      m_len = g ? DW : SW;
      m_word = g ? SW'(rif.DYN_DATA) : rif.STAT_DATA;
      m_pos = 0;
      m_act = 1;
      m_ack = 1;
    end else if (m_act) begin
      if (m_pos == m_len + 1) m_act = 0;
      else m_pos++;
    end
  endtask

  function automatic logic [6:0] exp_outs();
    logic a_d, a_s, sd, ss, dt, bz, dn;
    {a_d, a_s, sd, ss, dt, bz, dn} = '0;
    if (m_act) begin
      bz = 1;
      a_d = m_ack && m_dyn;
      a_s = m_ack && !m_dyn;
      if (m_pos < m_len) begin
        if (m_dyn) sd = 1; else ss = 1;
        dt = m_word[m_len - 1 - m_pos];
      end else if (m_pos == m_len) begin
        if (m_dyn) ss = 1; else sd = 1;
      end else begin
        dn = 1;
      end
    end
    return {a_d, a_s, sd, ss, dt, bz, dn};
  endfunction

  task automatic check_cycle();
    logic [6:0] e;
    logic [6:0] o;
    e = exp_outs();
    o = {rif.DYN_ACK, rif.STAT_ACK, seldyn, selstat,
         sdata, busy, done};
    chk("outs", SW'(o), SW'(e));
    if (e[0]) begin
      if (m_dyn) chk("dynlatch", SW'(dlatch), m_word);
      else chk("statlatch", slatch, m_word);
    end
  endtask

  int dyn_more = 0;
  int stat_more = 0;
  bit force_rst = 0;
  logic [DW-1:0] dq[$];
  logic [SW-1:0] sq[$];
  bit order[$];

  always @(negedge clk) begin
    if (rif.DYN_ACK === 1'b1) order.push_back(1'b1);
    if (rif.STAT_ACK === 1'b1) order.push_back(1'b0);
  end

  function automatic logic [SW-1:0] rnd_stat();
    return SW'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic drive(input bit rnd);
    rst = force_rst || (rnd && $urandom_range(0, 399) == 0);
    if (rif.DYN_ACK) begin
      if (dyn_more > 0 && dq.size() > 0) begin
        dyn_more--;
        rif.DYN_DATA = dq.pop_front();
      end else begin
        rif.DYN_REQ = 0;
      end
    end else if (rnd) begin
      if (!rif.DYN_REQ && $urandom_range(0, 7) == 0) begin
        rif.DYN_REQ = 1;
        rif.DYN_DATA = DW'($urandom());
      end else if (rif.DYN_REQ &&
                   $urandom_range(0, 63) == 0) begin
        rif.DYN_REQ = 0;
      end
    end
    if (rif.STAT_ACK) begin
      if (stat_more > 0 && sq.size() > 0) begin
        stat_more--;
        rif.STAT_DATA = sq.pop_front();
      end else begin
        rif.STAT_REQ = 0;
      end
    end else if (rnd) begin
      if (!rif.STAT_REQ && $urandom_range(0, 15) == 0) begin
        rif.STAT_REQ = 1;
        rif.STAT_DATA = rnd_stat();
      end else if (rif.STAT_REQ &&
                   $urandom_range(0, 63) == 0) begin
        rif.STAT_REQ = 0;
      end
    end
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      check_cycle();
      drive(rnd);
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    force_rst = 1;
    run(2, 0);
    force_rst = 0;
  endtask

  logic [SW-1:0] sl_keep;
  int busy_cnt;

  initial begin
    rif.DYN_REQ = 0;
    rif.DYN_DATA = '0;
    rif.STAT_REQ = 0;
    rif.STAT_DATA = '0;
    force_rst = 1;
    rst = 1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    run(2, 0);
    force_rst = 0;

    // single dynamic load
    rif.DYN_DATA = 16'h1234;
    rif.DYN_REQ = 1;
    run(20, 0);
    chk("dyn_1234", SW'(dlatch), SW'(16'h1234));

    // single static load, BUSY span counted
    rif.STAT_DATA = 88'hFEDCBA9876543210FEDCBA;
    rif.STAT_REQ = 1;
    busy_cnt = 0;
    for (int i = 0; i < 94; i++) begin
      run(1, 0);
      if (busy) busy_cnt++;
    end
    chk("stat_word", slatch, 88'hFEDCBA9876543210FEDCBA);
    chk("busy_len", SW'(busy_cnt), SW'(90));

    // simultaneous requests out of reset
    do_reset();
    order.delete();
    dq.push_back(DW'($urandom()));
    sq.push_back(rnd_stat());
    dyn_more = 1;
    stat_more = 1;
    rif.DYN_DATA = DW'($urandom());
    rif.STAT_DATA = rnd_stat();
    rif.DYN_REQ = 1;
    rif.STAT_REQ = 1;
    run(2 * (DW + 2 + SW + 2) + 4, 0);
    chk("njobs", SW'(order.size()), SW'(4));
    if (order.size() >= 4)
      chk("order", SW'({order[0], order[1], order[2], order[3]}),
          SW'(4'b1010));

    // back-to-back dynamic with REQ held
    rif.DYN_DATA = 16'hAAAA;
    dq.delete();
    dq.push_back(16'h5555);
    dyn_more = 1;
    rif.DYN_REQ = 1;
    run(40, 0);
    chk("dyn_b2b", SW'(dlatch), SW'(16'h5555));

    // reset at static shift bit 40
    sl_keep = slatch;
    rif.STAT_DATA = rnd_stat();
    rif.STAT_REQ = 1;
    run(41, 0);
    force_rst = 1;
    run(1, 0);
    force_rst = 0;
    run(4, 0);
    chk("stat_keep", slatch, sl_keep);
    rif.DYN_DATA = 16'hC3A5;
    rif.DYN_REQ = 1;
    run(20, 0);
    chk("dyn_after_rst", SW'(dlatch), SW'(16'hC3A5));

    // randomised traffic with withdrawals and resets
    run(3000, 1);
    rif.DYN_REQ = 0;
    rif.STAT_REQ = 0;
    run(100, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
